// File: rtl/scan_seq_74138.sv
// Scan sequencer driving a 74138 3-to-8 decoder: per channel a blanking gap, then a dwell with enables on.
// Optional build macro SCAN_SEQ_GRAY_EN selects Gray-order channel stepping instead of binary order.
module scan_seq_74138 #(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int NUM_CH       = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       oneshot_i,
    output logic       select_a_o,
    output logic       select_b_o,
    output logic       select_c_o,
    output logic       g1_en_o,
    output logic       g2a_en_n_o,
    output logic       g2b_en_n_o,
    output logic [2:0] ch_o,
    output logic       busy_o,
    output logic       frame_done_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DWELL = 2'd2;

    localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [2:0]    LAST_STEP  = 3'(NUM_CH - 1);

    generate
        if (BLANK_CYCLES < 2) begin : g_chk_blank
            $error("scan_seq_74138: BLANK_CYCLES must be >= 2");
        end
        if (DWELL_CYCLES < 1) begin : g_chk_dwell
            $error("scan_seq_74138: DWELL_CYCLES must be >= 1");
        end
        if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
            $error("scan_seq_74138: NUM_CH must be in 1..8");
        end
    endgenerate

    // Physical decoder channel for a scan step; binary-to-Gray gives 0,1,3,2,6,7,5,4.
    function automatic logic [2:0] step_to_ch(input logic [2:0] step);
`ifdef SCAN_SEQ_GRAY_EN
        return step ^ {1'b0, step[2:1]};
`else
        return step;
`endif
    endfunction

    logic [1:0]    r_rst_sync;
    logic          w_rst_n;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_step;
    logic [2:0]    r_sel;
    logic          r_en;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_stop_pend;
    logic          w_cnt_done;
    logic          w_last;
    logic          w_stop;

    // NOTE: reset asserts asynchronously but releases only after two clean clock edges,
    // so no state flop sees the release near an active edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n    = r_rst_sync[1];
    assign w_cnt_done = (r_cnt == '0);
    assign w_last     = (r_step == LAST_STEP);
    assign w_stop     = r_stop_pend | stop_i;

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_step       <= 3'd0;
            r_sel        <= 3'd0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_stop_pend  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i && !stop_i) begin
                        r_state     <= S_BLANK;
                        r_step      <= 3'd0;
                        r_cnt       <= BLANK_LOAD;
                        r_busy      <= 1'b1;
                        r_stop_pend <= 1'b0;
                    end
                end
                S_BLANK: begin
                    if (stop_i) r_stop_pend <= 1'b1;
                    // Enables went off on the previous edge, so the select change is glitch-free.
                    if (r_cnt == BLANK_LOAD) r_sel <= step_to_ch(r_step);
                    if (w_cnt_done) begin
                        r_state <= S_DWELL;
                        r_cnt   <= DWELL_LOAD;
                        r_en    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DWELL: begin
                    if (stop_i) r_stop_pend <= 1'b1;
                    if (w_cnt_done) begin
                        r_en <= 1'b0;
                        if (w_last) r_frame_done <= 1'b1;
                        // NOTE: non-blocking assignments to the same flop: the later one in
                        // this block wins, so leaving for IDLE always clears the pending stop.
                        if (w_stop || (w_last && oneshot_i)) begin
                            r_state     <= S_IDLE;
                            r_busy      <= 1'b0;
                            r_stop_pend <= 1'b0;
                        end else begin
                            r_state <= S_BLANK;
                            r_cnt   <= BLANK_LOAD;
                            r_step  <= w_last ? 3'd0 : r_step + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign select_a_o   = r_sel[0];
    assign select_b_o   = r_sel[1];
    assign select_c_o   = r_sel[2];
    assign ch_o         = r_sel;
    assign g1_en_o      = r_en;
    assign g2a_en_n_o   = ~r_en;
    assign g2b_en_n_o   = ~r_en;
    assign busy_o       = r_busy;
    assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_scan_seq_74138.sv
// Directed bench for scan_seq_74138 (DWELL=4, BLANK=2, NUM_CH=8); honours SCAN_SEQ_GRAY_EN for the channel order.
module tb_scan_seq_74138;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int NC    = 8;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = NC * SLOT;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       oneshot_i = 1'b0;
    logic       select_a_o, select_b_o, select_c_o;
    logic       g1_en_o, g2a_en_n_o, g2b_en_n_o;
    logic [2:0] ch_o;
    logic       busy_o, frame_done_o;

    int n_checks = 0;
    int n_fail   = 0;

    scan_seq_74138 #(
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BL),
        .NUM_CH      (NC)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .oneshot_i   (oneshot_i),
        .select_a_o  (select_a_o),
        .select_b_o  (select_b_o),
        .select_c_o  (select_c_o),
        .g1_en_o     (g1_en_o),
        .g2a_en_n_o  (g2a_en_n_o),
        .g2b_en_n_o  (g2b_en_n_o),
        .ch_o        (ch_o),
        .busy_o      (busy_o),
        .frame_done_o(frame_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed vector: {busy, g1, g2a_n, g2b_n, frame_done, ch[2:0], C, B, A}
    logic [10:0] obs;
    assign obs = {busy_o, g1_en_o, g2a_en_n_o, g2b_en_n_o, frame_done_o, ch_o,
                  select_c_o, select_b_o, select_a_o};

    function automatic logic [2:0] chmap(input int step);
`ifdef SCAN_SEQ_GRAY_EN
        logic [2:0] g [0:7];
        g = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
        return g[step];
`else
        return 3'(step);
`endif
    endfunction

    // Expected outputs t cycles after the start edge while scanning; prev = selects held before start.
    function automatic logic [10:0] exp_run(input int t, input logic [2:0] prev);
        int step  = (t / SLOT) % NC;
        int pos   = t % SLOT;
        int frame = t / FRAME;
        logic [2:0] sel;
        logic en;
        logic fd;
        if (pos == 0)
            sel = (step == 0) ? ((frame == 0) ? prev : chmap(NC - 1)) : chmap(step - 1);
        else
            sel = chmap(step);
        en = (pos >= BL);
        fd = (t > 0) && (t % FRAME == 0);
        return {1'b1, en, ~en, ~en, fd, sel, sel};
    endfunction

    function automatic logic [10:0] exp_idle(input logic [2:0] sel, input logic fd);
        return {4'b0011, fd, sel, sel};
    endfunction

    // Continuous invariants: selects frozen while enabled; Gray steps differ in one bit.
    logic       mon_prev_g1 = 1'b0;
    logic [2:0] mon_prev_sel = 3'd0;
    logic [2:0] mon_last_dwell = 3'd0;
    logic       mon_have = 1'b0;

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            if (g1_en_o && mon_prev_g1) begin
                n_checks++;
                if (ch_o !== mon_prev_sel) begin
                    n_fail++;
                    $display("FAIL sel_stable_in_dwell got=%0d required=%0d", ch_o, mon_prev_sel);
                end
            end
`ifdef SCAN_SEQ_GRAY_EN
            if (g1_en_o && !mon_prev_g1) begin
                if (mon_have && ch_o !== chmap(0)) begin
                    n_checks++;
                    if ($countones(ch_o ^ mon_last_dwell) != 1) begin
                        n_fail++;
                        $display("FAIL gray_hamming got=%0d->%0d required distance 1",
                                 mon_last_dwell, ch_o);
                    end
                end
                mon_last_dwell <= ch_o;
                mon_have       <= 1'b1;
            end
`endif
            if (!busy_o) mon_have <= 1'b0;
        end
        mon_prev_g1  <= g1_en_o;
        mon_prev_sel <= ch_o;
    end

    task automatic test_reset();
        rst_n_i   = 1'b0;
        start_i   = 1'b0;
        stop_i    = 1'b0;
        oneshot_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_i);
            n_checks++;
            if (obs !== exp_idle(3'd0, 1'b0)) begin
                n_fail++;
                $display("FAIL reset_idle t=%0d got=%h required=%h", t, obs, exp_idle(3'd0, 1'b0));
            end
        end
    endtask

    // One frame; a redundant start pulse mid-frame must be ignored.
    task automatic test_oneshot(input logic [2:0] prev);
        logic [10:0] e;
        oneshot_i = 1'b1;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int t = 0; t <= FRAME + 4; t++) begin
            e = (t < FRAME) ? exp_run(t, prev) : exp_idle(chmap(NC - 1), t == FRAME);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL oneshot t=%0d got=%h required=%h", t, obs, e);
            end
            if (t == 10) start_i = 1'b1;
            if (t == 11) start_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    // Three back-to-back frames, then oneshot raised so the fourth frame ends in IDLE.
    task automatic test_back_to_back(input logic [2:0] prev);
        logic [10:0] e;
        oneshot_i = 1'b0;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int t = 0; t <= 4 * FRAME + 4; t++) begin
            e = (t < 4 * FRAME) ? exp_run(t, prev) : exp_idle(chmap(NC - 1), t == 4 * FRAME);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL back_to_back t=%0d got=%h required=%h", t, obs, e);
            end
            if (t == 3 * FRAME) oneshot_i = 1'b1;
            @(negedge clk_i);
        end
    endtask

    // Stop during the channel-3 dwell: that dwell completes, then IDLE with no frame_done.
    task automatic test_stop(input logic [2:0] prev);
        logic [10:0] e;
        oneshot_i = 1'b0;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int t = 0; t <= 30; t++) begin
            e = (t < 4 * SLOT) ? exp_run(t, prev) : exp_idle(chmap(3), 1'b0);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL stop t=%0d got=%h required=%h", t, obs, e);
            end
            if (t == 3 * SLOT + BL + 1) stop_i = 1'b1;
            if (t == 3 * SLOT + BL + 2) stop_i = 1'b0;
            @(negedge clk_i);
        end
    endtask

    task automatic test_start_stop_same(input logic [2:0] held);
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        stop_i  = 1'b0;
        for (int t = 0; t < 6; t++) begin
            n_checks++;
            if (obs !== exp_idle(held, 1'b0)) begin
                n_fail++;
                $display("FAIL start_stop_same t=%0d got=%h required=%h", t, obs, exp_idle(held, 1'b0));
            end
            @(negedge clk_i);
        end
    endtask

    // Reset asserted mid-dwell of channel 5, checked before the next rising edge.
    task automatic test_reset_mid(input logic [2:0] prev);
        logic [10:0] e;
        oneshot_i = 1'b1;
        start_i   = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int t = 0; t <= 5 * SLOT + BL + 1; t++) begin
            e = exp_run(t, prev);
            n_checks++;
            if (obs !== e) begin
                n_fail++;
                $display("FAIL pre_reset t=%0d got=%h required=%h", t, obs, e);
            end
            if (t != 5 * SLOT + BL + 1) @(negedge clk_i);
        end
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (obs !== exp_idle(3'd0, 1'b0)) begin
            n_fail++;
            $display("FAIL async_reset got=%h required=%h", obs, exp_idle(3'd0, 1'b0));
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk_i);
            n_checks++;
            if (obs !== exp_idle(3'd0, 1'b0)) begin
                n_fail++;
                $display("FAIL post_reset_idle t=%0d got=%h required=%h", t, obs, exp_idle(3'd0, 1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot(3'd0);
        test_back_to_back(chmap(NC - 1));
        test_stop(chmap(NC - 1));
        test_start_stop_same(chmap(3));
        test_reset_mid(chmap(3));
        test_oneshot(3'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
